id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered decode stage between IF and EX: decodes RV32 subset, reads regfile, builds operands,
//  resolves BEQ/BNE in ID, and holds results in an ID/EX pipeline register with valid/ready handshake.
//  Detects load-use hazards and stalls IF for one cycle; supports flush from downstream redirect.
// PARAMETERS
//  XLEN       32  datapath / operand width
//  RF_ADDR_W  5   register address width
//  ALU_OP_W   4   alu_op width; encodings per riscv_define_all.v (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/LW/SW/BEQ/BNE_ALU)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-high
//  in_valid       in   1          IF presents in_pc/in_inst
//  in_ready       out  1          ID accepts this cycle
//  in_pc          in   XLEN       instruction PC
//  in_inst        in   32         instruction word
//  rs1_addr       out  RF_ADDR_W  regfile read addr 1 (comb, 0 when unused)
//  rs2_addr       out  RF_ADDR_W  regfile read addr 2 (comb, 0 when unused)
//  rs1_data       in   XLEN       regfile read data 1 (comb)
//  rs2_data       in   XLEN       regfile read data 2 (comb)
//  flush          in   1          kill pipeline register and incoming instruction
//  out_ready      in   1          EX accepts ID/EX register
//  out_valid      out  1          ID/EX register holds an instruction
//  out_pc, out_op1, out_op2, out_mem_offset  out  XLEN  registered operands / store-load offset
//  out_rd_addr    out  RF_ADDR_W  registered dest; out_rd_we out 1; out_alu_op out ALU_OP_W
//  br_taken       out  1          comb: accepted branch taken this cycle; br_target out XLEN
//  illegal_inst   out  1          registered one-cycle pulse on accepted unknown encoding
// BEHAVIOUR
//  - Reset: all registered outputs 0, out_valid=0, illegal_inst=0; state IDLE.
//  - Decode: R-type (funct3/funct7 -> ADD,SUB,AND,OR,XOR,SLL,SRL,SRA), ADDI (op2=sext I-imm),
//    LW (op1=rs1, mem_offset=sext I-imm, rd_we=1), SW (op1=rs1, op2=rs2, mem_offset=sext S-imm, rd_we=0),
//    BEQ/BNE (rd_we=0). Unused rs addr driven 0, its operand 0. rd==0 forces rd_we=0.
//  - Unknown opcode/funct: accepted, illegal_inst pulse, enters register as bubble (out_valid=0).
//  - Register load enable: ld = ~out_valid | out_ready. in_ready = ld & ~stall.
//  - Stall (load-use): out_valid & out_alu_op==LW_ALU & out_rd_we & out_rd_addr!=0 & matches a used
//    rs of in_inst. While stall & ld: register loads bubble (out_valid=0); next cycle hazard clears.
//    Exactly one bubble per load-use; branch in stall waits, br_taken=0 until accepted.
//  - Accept: in_valid & in_ready & ~flush -> register <= decoded fields, out_valid=1 next edge.
//    Held stable while out_valid & ~out_ready (no field may change).
//  - Branch: br_taken = accept & BEQ/BNE & (op1==op2 / op1!=op2); br_target = in_pc + sext B-imm
//    (wraps mod 2^XLEN). Branch itself still passes to EX with rd_we=0.
//  - Flush: next edge out_valid=0 regardless of out_ready/stall; in_ready=1, incoming dropped,
//    br_taken=0. Flush dominates stall and accept.
//  - Reset mid-operation: immediate clear, pending stall/branch discarded.
// CONFIGURATION
//  FORWARD_EN defined: adds ports fwd_ex_we/fwd_ex_rd/fwd_ex_data and fwd_mem_we/fwd_mem_rd/fwd_mem_data;
//    operands (incl. branch compare and SW store data) select EX over MEM over regfile on rd match,
//    never for rd==0. Load-use stall still applies (EX load data not forwardable).
//  FORWARD_EN undefined: ports absent; operands from regfile only; software inserts NOPs for RAW.
// TESTING
//  - reset high mid-stream with out_valid=1 -> out_valid=0, all outputs 0 asynchronously.
//  - ADDI x5,x0,-4 then ADD x6,x5,x5 (FORWARD_EN, fwd_ex x5=0xFFFFFFFC) -> out_op1=out_op2=0xFFFFFFFC.
//  - LW x7,8(x1) then AND x8,x7,x2 -> in_ready=0 one cycle, one bubble, AND issues next cycle.
//  - BEQ x1,x2,+16 at pc=0x100, x1=x2=3 -> br_taken=1, br_target=0x110; x1!=x2 -> br_taken=0.
//  - out_ready=0 for 3 cycles with SW held -> outputs unchanged; flush during stall -> out_valid=0.
//  - inst=0xFFFFFFFF -> illegal_inst pulses 1 cycle, out_valid=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32-subset decode stage: regfile read, operand build, BEQ/BNE resolution, ID/EX register.
// Define FORWARD_EN to add EX/MEM operand forwarding ports (EX has priority over MEM).
module id_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5,
    parameter int unsigned ALU_OP_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    output logic [RF_ADDR_W-1:0] rs1_addr,
    output logic [RF_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
`ifdef FORWARD_EN
    input  logic                 fwd_ex_we,
    input  logic [RF_ADDR_W-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]      fwd_ex_data,
    input  logic                 fwd_mem_we,
    input  logic [RF_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]      fwd_mem_data,
`endif
    input  logic                 flush,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_mem_offset,
    output logic [RF_ADDR_W-1:0] out_rd_addr,
    output logic                 out_rd_we,
    output logic [ALU_OP_W-1:0]  out_alu_op,
    output logic                 br_taken,
    output logic [XLEN-1:0]      br_target,
    output logic                 illegal_inst
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_LW  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SW  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_BEQ = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] ALU_BNE = ALU_OP_W'(11);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {StIdle, StFull} state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, off_q, off_d;
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic [ALU_OP_W-1:0]  op_q, op_d;
    logic                 we_q, we_d, ill_q, ill_d;

    // Instruction fields
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode = in_inst[6:0];
    assign rd_f   = in_inst[11:7];
    assign funct3 = in_inst[14:12];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign funct7 = in_inst[31:25];

    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};

    logic                dec_legal, use_rs1, use_rs2, has_rd, op2_imm, is_branch, is_bne;
    logic [ALU_OP_W-1:0] dec_op;
    logic [XLEN-1:0]     dec_off;

    always_comb begin
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        has_rd    = 1'b0;
        op2_imm   = 1'b0;
        is_branch = 1'b0;
        is_bne    = 1'b0;
        dec_op    = ALU_ADD;
        dec_off   = '0;
        case (opcode)
            OPC_OP: begin
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                has_rd    = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = ALU_ADD;
                    10'b0100000_000: dec_op = ALU_SUB;
                    10'b0000000_111: dec_op = ALU_AND;
                    10'b0000000_110: dec_op = ALU_OR;
                    10'b0000000_100: dec_op = ALU_XOR;
                    10'b0000000_001: dec_op = ALU_SLL;
                    10'b0000000_101: dec_op = ALU_SRL;
                    10'b0100000_101: dec_op = ALU_SRA;
                    default:         dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    use_rs1   = 1'b1;
                    has_rd    = 1'b1;
                    op2_imm   = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    use_rs1   = 1'b1;
                    has_rd    = 1'b1;
                    dec_op    = ALU_LW;
                    dec_off   = imm_i;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    dec_op    = ALU_SW;
                    dec_off   = imm_s;
                end
            end
            OPC_BRANCH: begin
                if (funct3[2:1] == 2'b00) begin
                    dec_legal = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    is_branch = 1'b1;
                    is_bne    = funct3[0];
                    dec_op    = funct3[0] ? ALU_BNE : ALU_BEQ;
                end
            end
            default: ;
        endcase
        // An unknown encoding reads nothing, so it can never cause a stall.
        if (!dec_legal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            has_rd  = 1'b0;
        end
    end

    assign rs1_addr = use_rs1 ? RF_ADDR_W'(rs1_f) : '0;
    assign rs2_addr = use_rs2 ? RF_ADDR_W'(rs2_f) : '0;

    logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef FORWARD_EN
    always_comb begin
        rs1_val = rs1_data;
        if (fwd_ex_we && fwd_ex_rd != '0 && fwd_ex_rd == rs1_addr) begin
            rs1_val = fwd_ex_data;
        end else if (fwd_mem_we && fwd_mem_rd != '0 && fwd_mem_rd == rs1_addr) begin
            rs1_val = fwd_mem_data;
        end
        rs2_val = rs2_data;
        if (fwd_ex_we && fwd_ex_rd != '0 && fwd_ex_rd == rs2_addr) begin
            rs2_val = fwd_ex_data;
        end else if (fwd_mem_we && fwd_mem_rd != '0 && fwd_mem_rd == rs2_addr) begin
            rs2_val = fwd_mem_data;
        end
    end
`else
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    logic [XLEN-1:0]      op1, op2;
    logic [RF_ADDR_W-1:0] dec_rd;
    logic                 dec_we;

    assign op1    = use_rs1 ? rs1_val : '0;
    assign op2    = op2_imm ? imm_i : (use_rs2 ? rs2_val : '0);
    assign dec_rd = has_rd ? RF_ADDR_W'(rd_f) : '0;
    assign dec_we = has_rd && (rd_f != 5'd0);

    // Handshake, load-use hazard against the instruction sitting in ID/EX
    logic ld, load_use, accept;

    assign out_valid = (state_q == StFull);
    assign ld        = !out_valid || out_ready;
    assign load_use  = out_valid && (op_q == ALU_LW) && we_q && (rd_q != '0) &&
                       ((use_rs1 && rs1_addr == rd_q) || (use_rs2 && rs2_addr == rd_q));
    assign in_ready  = flush || (ld && !load_use);
    assign accept    = in_valid && in_ready && !flush;

    assign br_target = in_pc + imm_b;
    assign br_taken  = accept && is_branch && ((op1 == op2) != is_bne);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        off_d   = off_q;
        rd_d    = rd_q;
        we_d    = we_q;
        op_d    = op_q;
        ill_d   = accept && !dec_legal;
        if (flush || (ld && !(accept && dec_legal))) begin
            state_d = StIdle;
            pc_d    = '0;
            op1_d   = '0;
            op2_d   = '0;
            off_d   = '0;
            rd_d    = '0;
            we_d    = 1'b0;
            op_d    = '0;
        end else if (ld) begin
            state_d = StFull;
            pc_d    = in_pc;
            op1_d   = op1;
            op2_d   = op2;
            off_d   = dec_off;
            rd_d    = dec_rd;
            we_d    = dec_we;
            op_d    = dec_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
        end
    end

    assign out_pc         = pc_q;
    assign out_op1        = op1_q;
    assign out_op2        = op2_q;
    assign out_mem_offset = off_q;
    assign out_rd_addr    = rd_q;
    assign out_rd_we      = we_q;
    assign out_alu_op     = op_q;
    assign illegal_inst   = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: mnemonic-level reference model checked every cycle, plus directed
// literal checks. Forwarding tests are included when FORWARD_EN is defined.
module tb_id_stage_pipe;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_LW = 4'd8, A_SW = 4'd9;
    localparam logic [3:0] A_BEQ = 4'd10, A_BNE = 4'd11;
    // {funct7, funct3} of the R-type ops other than ADD
    localparam logic [9:0] ROPS [7] = '{10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h005,
                                        10'h105};

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic [4:0]  rs1_addr, rs2_addr, out_rd_addr;
    logic [31:0] rs1_data, rs2_data, out_pc, out_op1, out_op2, out_mem_offset, br_target;
    logic        in_ready, out_valid, out_rd_we, br_taken, illegal_inst;
    logic [3:0]  out_alu_op;
    logic [31:0] rf [32];
`ifdef FORWARD_EN
    logic        fwd_ex_we = 1'b0, fwd_mem_we = 1'b0;
    logic [4:0]  fwd_ex_rd = '0, fwd_mem_rd = '0;
    logic [31:0] fwd_ex_data = '0, fwd_mem_data = '0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
`ifdef FORWARD_EN
        .fwd_ex_we      (fwd_ex_we),
        .fwd_ex_rd      (fwd_ex_rd),
        .fwd_ex_data    (fwd_ex_data),
        .fwd_mem_we     (fwd_mem_we),
        .fwd_mem_rd     (fwd_mem_rd),
        .fwd_mem_data   (fwd_mem_data),
`endif
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_op1        (out_op1),
        .out_op2        (out_op2),
        .out_mem_offset (out_mem_offset),
        .out_rd_addr    (out_rd_addr),
        .out_rd_we      (out_rd_we),
        .out_alu_op     (out_alu_op),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .illegal_inst   (illegal_inst)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, op1, op2, off;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  op;
        logic        ill;
    } slot_t;

    typedef struct packed {
        logic        legal, u1, u2, br, bne;
        logic [4:0]  r1, r2;
        logic [31:0] tgt;
        slot_t       s;
    } dec_t;

    slot_t m = '0;
    slot_t mn = '0;

    function automatic logic [31:0] mdl_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef FORWARD_EN
        if (fwd_ex_we && fwd_ex_rd == r) return fwd_ex_data;
        if (fwd_mem_we && fwd_mem_rd == r) return fwd_mem_data;
`endif
        return rf[r];
    endfunction

    function automatic dec_t mdl_decode(input logic [31:0] i, input logic [31:0] pc);
        dec_t        d;
        string       mn_s;
        logic        wr;
        logic [31:0] immi, imms, immb;
        d    = '0;
        mn_s = "ill";
        immi = 32'($signed(i[31:20]));
        imms = 32'($signed({i[31:25], i[11:7]}));
        immb = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        case (i[6:0])
            7'h33: begin
                case ({i[31:25], i[14:12]})
                    10'h000: mn_s = "add";
                    10'h100: mn_s = "sub";
                    10'h007: mn_s = "and";
                    10'h006: mn_s = "or";
                    10'h004: mn_s = "xor";
                    10'h001: mn_s = "sll";
                    10'h005: mn_s = "srl";
                    10'h105: mn_s = "sra";
                    default: mn_s = "ill";
                endcase
            end
            7'h13: if (i[14:12] == 3'd0) mn_s = "addi";
            7'h03: if (i[14:12] == 3'd2) mn_s = "lw";
            7'h23: if (i[14:12] == 3'd2) mn_s = "sw";
            7'h63: begin
                if (i[14:12] == 3'd0) mn_s = "beq";
                else if (i[14:12] == 3'd1) mn_s = "bne";
            end
            default: ;
        endcase
        d.legal = (mn_s != "ill");
        d.u1    = d.legal;
        d.u2    = d.legal && mn_s != "addi" && mn_s != "lw";
        wr      = d.legal && mn_s != "sw" && mn_s != "beq" && mn_s != "bne";
        d.r1    = d.u1 ? i[19:15] : 5'd0;
        d.r2    = d.u2 ? i[24:20] : 5'd0;
        d.br    = (mn_s == "beq") || (mn_s == "bne");
        d.bne   = (mn_s == "bne");
        d.tgt   = pc + immb;
        d.s.valid = 1'b1;
        d.s.pc    = pc;
        d.s.op1   = d.u1 ? mdl_reg(d.r1) : 32'h0;
        d.s.op2   = (mn_s == "addi") ? immi : (d.u2 ? mdl_reg(d.r2) : 32'h0);
        d.s.off   = (mn_s == "lw") ? immi : ((mn_s == "sw") ? imms : 32'h0);
        d.s.rd    = wr ? i[11:7] : 5'd0;
        d.s.we    = wr && i[11:7] != 5'd0;
        if (mn_s == "sub") d.s.op = A_SUB;
        else if (mn_s == "and") d.s.op = A_AND;
        else if (mn_s == "or") d.s.op = A_OR;
        else if (mn_s == "xor") d.s.op = A_XOR;
        else if (mn_s == "sll") d.s.op = A_SLL;
        else if (mn_s == "srl") d.s.op = A_SRL;
        else if (mn_s == "sra") d.s.op = A_SRA;
        else if (mn_s == "lw") d.s.op = A_LW;
        else if (mn_s == "sw") d.s.op = A_SW;
        else if (mn_s == "beq") d.s.op = A_BEQ;
        else if (mn_s == "bne") d.s.op = A_BNE;
        else d.s.op = A_ADD;
        return d;
    endfunction

    always @(negedge clk) begin : cmp
        dec_t d;
        logic hz, can_ld, rdy, take, tk;
        d      = mdl_decode(in_inst, in_pc);
        hz     = m.valid && m.op == A_LW && m.we && m.rd != 5'd0 &&
                 ((d.u1 && d.r1 == m.rd) || (d.u2 && d.r2 == m.rd));
        can_ld = !m.valid || out_ready;
        rdy    = flush || (can_ld && !hz);
        take   = in_valid && rdy && !flush;
        tk     = take && d.br && ((d.s.op1 == d.s.op2) != d.bne);
        chk("m_out_valid", 32'(out_valid), 32'(m.valid));
        chk("m_out_pc", out_pc, m.pc);
        chk("m_out_op1", out_op1, m.op1);
        chk("m_out_op2", out_op2, m.op2);
        chk("m_out_mem_offset", out_mem_offset, m.off);
        chk("m_out_rd_addr", 32'(out_rd_addr), 32'(m.rd));
        chk("m_out_rd_we", 32'(out_rd_we), 32'(m.we));
        chk("m_out_alu_op", 32'(out_alu_op), 32'(m.op));
        chk("m_illegal_inst", 32'(illegal_inst), 32'(m.ill));
        chk("m_in_ready", 32'(in_ready), 32'(rdy));
        chk("m_br_taken", 32'(br_taken), 32'(tk));
        chk("m_rs1_addr", 32'(rs1_addr), 32'(d.r1));
        chk("m_rs2_addr", 32'(rs2_addr), 32'(d.r2));
        if (in_valid && d.br) chk("m_br_target", br_target, d.tgt);
        if (reset || flush) begin
            mn = '0;
        end else if (can_ld) begin
            mn     = (take && d.legal) ? d.s : '0;
            mn.ill = take && !d.legal;
        end else begin
            mn     = m;
            mn.ill = 1'b0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) m = '0;
        else m = mn;
    end

    // ---------------- encoders and stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic put(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = v ? inst : 32'h0;
        in_pc    = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        logic done;
        done = 1'b0;
        put(1'b1, inst, pc);
        for (int k = 0; k < 8 && !done; k++) begin
            #1;
            done = in_ready && !flush;
            tick;
        end
        chk("issue_accepted", 32'(done), 32'd1);
        put(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        rf[1] = 32'd3;
        rf[2] = 32'd3;
        rf[3] = 32'h1234_5678;
        rf[4] = 32'd5;
        rf[9] = 32'h8000_0001;
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal_inst), 32'd0);
        chk("rst_out_op1", out_op1, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick;
        tick;
        reset = 1'b0;
        tick;

        // ADD x6,x3,x4
        issue(enc_r(7'h00, 3'd0, 5'd6, 5'd3, 5'd4), 32'h40);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_op1", out_op1, 32'h1234_5678);
        chk("add_op2", out_op2, 32'd5);
        chk("add_rd", 32'(out_rd_addr), 32'd6);
        chk("add_pc", out_pc, 32'h40);

        for (int k = 0; k < 7; k++) begin
            issue(enc_r(ROPS[k][9:3], ROPS[k][2:0], 5'(10 + k), 5'd9, 5'd4), 32'(32'h80 + 4 * k));
        end
        chk("sra_op", 32'(out_alu_op), 32'(A_SRA));

        // ADDI x5,x0,-4
        issue(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'hFFC), 32'h60);
        chk("addi_op2", out_op2, 32'hFFFF_FFFC);
        chk("addi_op1", out_op1, 32'h0);
        // ADD x0,x1,x2: destination x0 never written
        issue(enc_r(7'h00, 3'd0, 5'd0, 5'd1, 5'd2), 32'h64);
        chk("rd0_we", 32'(out_rd_we), 32'd0);

        // LW x7,8(x1) then AND x8,x7,x2: exactly one bubble
        issue(enc_i(7'h03, 3'd2, 5'd7, 5'd1, 12'd8), 32'h70);
        chk("lw_op", 32'(out_alu_op), 32'(A_LW));
        chk("lw_off", out_mem_offset, 32'd8);
        chk("lw_op1", out_op1, 32'd3);
        put(1'b1, enc_r(7'h00, 3'd7, 5'd8, 5'd7, 5'd2), 32'h74);
        #1 chk("lu_stall_ready", 32'(in_ready), 32'd0);
        tick;
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_ready_after", 32'(in_ready), 32'd1);
        tick;
        put(1'b0, 32'h0, 32'h0);
        chk("lu_and_valid", 32'(out_valid), 32'd1);
        chk("lu_and_op", 32'(out_alu_op), 32'(A_AND));

        // BEQ x1,x2,+16 at 0x100, taken then not taken
        put(1'b1, enc_b(3'd0, 5'd1, 5'd2, 13'd16), 32'h100);
        #1 chk("beq_taken", 32'(br_taken), 32'd1);
        chk("beq_target", br_target, 32'h110);
        tick;
        put(1'b0, 32'h0, 32'h0);
        chk("beq_rd_we", 32'(out_rd_we), 32'd0);
        rf[2] = 32'd4;
        put(1'b1, enc_b(3'd0, 5'd1, 5'd2, 13'd16), 32'h100);
        #1 chk("beq_not_taken", 32'(br_taken), 32'd0);
        chk("beq_nt_target", br_target, 32'h110);
        tick;
        // BNE x1,x2,-8 at 0x200
        put(1'b1, enc_b(3'd1, 5'd1, 5'd2, 13'h1FF8), 32'h200);
        #1 chk("bne_taken", 32'(br_taken), 32'd1);
        chk("bne_target", br_target, 32'h1F8);
        tick;
        // BEQ x1,x1,-4 at 0: target wraps
        put(1'b1, enc_b(3'd0, 5'd1, 5'd1, 13'h1FFC), 32'h0);
        #1 chk("wrap_target", br_target, 32'hFFFF_FFFC);
        tick;
        put(1'b0, 32'h0, 32'h0);
        rf[2] = 32'd3;

        // Branch held back by a load-use stall
        issue(enc_i(7'h03, 3'd2, 5'd7, 5'd1, 12'd0), 32'h4F0);
        put(1'b1, enc_b(3'd1, 5'd7, 5'd1, 13'd16), 32'h500);
        #1 chk("br_stall_taken", 32'(br_taken), 32'd0);
        tick;
        chk("br_after_stall", 32'(br_taken), 32'd1);
        tick;
        put(1'b0, 32'h0, 32'h0);

        // SW x2,12(x1) held for 3 cycles, then flushed
        issue(enc_s(5'd2, 5'd1, 12'd12), 32'h300);
        out_ready = 1'b0;
        put(1'b1, enc_r(7'h00, 3'd0, 5'd6, 5'd3, 5'd4), 32'h304);
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_ready", 32'(in_ready), 32'd0);
            tick;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_op2", out_op2, 32'd3);
            chk("hold_off", out_mem_offset, 32'd12);
            chk("hold_op", 32'(out_alu_op), 32'(A_SW));
        end
        flush = 1'b1;
        #1 chk("flush_ready", 32'(in_ready), 32'd1);
        tick;
        flush = 1'b0;
        put(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        chk("flush_hold_valid", 32'(out_valid), 32'd0);

        // Flush during a load-use stall, and flush suppressing a taken branch
        issue(enc_i(7'h03, 3'd2, 5'd7, 5'd1, 12'd4), 32'h600);
        put(1'b1, enc_r(7'h00, 3'd7, 5'd8, 5'd7, 5'd2), 32'h604);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        put(1'b0, 32'h0, 32'h0);
        chk("flush_stall_valid", 32'(out_valid), 32'd0);
        tick;
        chk("flush_dropped", 32'(out_valid), 32'd0);
        put(1'b1, enc_b(3'd0, 5'd1, 5'd2, 13'd16), 32'h700);
        flush = 1'b1;
        #1 chk("flush_br_taken", 32'(br_taken), 32'd0);
        tick;
        flush = 1'b0;
        put(1'b0, 32'h0, 32'h0);

        // Unknown encodings
        put(1'b1, 32'hFFFF_FFFF, 32'h400);
        tick;
        put(1'b0, 32'h0, 32'h0);
        chk("ill_pulse", 32'(illegal_inst), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        tick;
        chk("ill_clear", 32'(illegal_inst), 32'd0);
        put(1'b1, enc_r(7'h01, 3'd0, 5'd6, 5'd3, 5'd4), 32'h404);
        tick;
        put(1'b0, 32'h0, 32'h0);
        chk("ill_mul_pulse", 32'(illegal_inst), 32'd1);
        tick;

`ifdef FORWARD_EN
        issue(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'hFFC), 32'h800);
        fwd_ex_we  = 1'b1;
        fwd_ex_rd  = 5'd5;
        fwd_ex_data = 32'hFFFF_FFFC;
        fwd_mem_we = 1'b1;
        fwd_mem_rd = 5'd5;
        fwd_mem_data = 32'h1111_1111;
        issue(enc_r(7'h00, 3'd0, 5'd6, 5'd5, 5'd5), 32'h804);
        chk("fwd_ex_op1", out_op1, 32'hFFFF_FFFC);
        chk("fwd_ex_op2", out_op2, 32'hFFFF_FFFC);
        fwd_ex_we = 1'b0;
        issue(enc_r(7'h00, 3'd0, 5'd6, 5'd5, 5'd5), 32'h808);
        chk("fwd_mem_op1", out_op1, 32'h1111_1111);
        fwd_mem_we = 1'b0;
        fwd_ex_we = 1'b1;
        fwd_ex_rd = 5'd0;
        fwd_ex_data = 32'hDEAD_BEEF;
        issue(enc_r(7'h00, 3'd0, 5'd6, 5'd0, 5'd1), 32'h80C);
        chk("fwd_x0_op1", out_op1, 32'h0);
        fwd_ex_we = 1'b0;
        tick;
`endif

        // Asynchronous reset while an instruction is held
        issue(enc_r(7'h00, 3'd0, 5'd6, 5'd3, 5'd4), 32'h900);
        out_ready = 1'b0;
        tick;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_op1", out_op1, 32'h0);
        chk("async_rst_pc", out_pc, 32'h0);
        chk("async_rst_op", 32'(out_alu_op), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
